// File: rtl/cpc_ram_ctrl.sv
// cpc_ram_ctrl: CPC 512K SRAM bank mapper and strobe sequencer (optional I/O read-back under CONFIG_READBACK_EN)
module cpc_ram_ctrl (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       a15,
    input  logic       a14,
    input  logic [7:0] d,
    input  logic       mreq_b,
    input  logic       ioreq_b,
    input  logic       rd_b,
    input  logic       wr_b,
    input  logic       m1_b,
    input  logic       rfsh_b,
    input  logic       ramrd_b,
    output logic [4:0] hiadr,
    output logic       ramcs_b,
    output logic       ramoe_b,
    output logic       ramwe_b,
    output logic       ramdis,
    output logic [7:0] dout,
    output logic       doe
);
    typedef enum logic [1:0] {IDLE, MEM, IO_WAIT, IO_RD} state_t;
    state_t state, state_n;
    logic [2:0] bank, cfg, bank_n, cfg_n;
    logic [4:0] hiadr_n;
    logic [1:0] blk, page;
    logic hit, mem_hit, cfg_wr, rd_hit, oe_in, we_in, cs_n, oe_n, we_n, dis_n;
    assign blk = {a15, a14};
    assign hit = (cfg == 3'd2) || ((cfg == 3'd1 || cfg == 3'd3) && blk == 2'd3) || (cfg[2] && blk == 2'd1);
    assign page = cfg == 3'd2 ? blk : cfg[2] ? cfg[1:0] : 2'd3;
    assign mem_hit = !mreq_b && rfsh_b && hit;
    assign cfg_wr = !ioreq_b && !wr_b && m1_b && !a15 && d[7:6] == 2'b11;
`ifdef CONFIG_READBACK_EN
    assign rd_hit = !ioreq_b && !rd_b && m1_b && !a15 && a14;
`else
    assign rd_hit = 1'b0;
`endif
    assign oe_in = rd_b | ramrd_b;
    assign we_in = wr_b | ~oe_in;
    // next state, config load and next strobe values
    always_comb begin
        state_n = state;
        bank_n = bank;
        cfg_n = cfg;
        hiadr_n = hiadr;
        cs_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
        dis_n = 1'b0;
        case (state)
            IDLE: begin
                if (mem_hit) begin
                    state_n = MEM;
                    hiadr_n = {bank, page};
                    cs_n = 1'b0;
                    dis_n = 1'b1;
                    oe_n = oe_in;
                    we_n = we_in;
                end else if (cfg_wr) begin
                    state_n = IO_WAIT;
                    bank_n = d[5:3];
                    cfg_n = d[2:0];
                end else if (rd_hit) begin
                    state_n = IO_RD;
                end
            end
            MEM: begin
                if (mreq_b) begin
                    state_n = IDLE;
                end else begin
                    cs_n = 1'b0;
                    dis_n = 1'b1;
                    oe_n = oe_in;
                    we_n = we_in;
                end
            end
            IO_WAIT: state_n = ioreq_b ? IDLE : IO_WAIT;
            IO_RD: state_n = (rd_b || ioreq_b) ? IO_WAIT : IO_RD;
            default: state_n = IDLE;
        endcase
    end
    // state, config and registered SRAM strobes
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state <= IDLE;
            bank <= '0;
            cfg <= '0;
            hiadr <= '0;
            ramcs_b <= 1'b1;
            ramoe_b <= 1'b1;
            ramwe_b <= 1'b1;
            ramdis <= 1'b0;
        end else begin
            state <= state_n;
            bank <= bank_n;
            cfg <= cfg_n;
            hiadr <= hiadr_n;
            ramcs_b <= cs_n;
            ramoe_b <= oe_n;
            ramwe_b <= we_n;
            ramdis <= dis_n;
        end
    end
`ifdef CONFIG_READBACK_EN
    // read-back data is driven only while the I/O read is in progress
    always_ff @(posedge clk) begin
        if (!reset_b) begin
            doe <= 1'b0;
            dout <= '0;
        end else begin
            doe <= state_n == IO_RD;
            dout <= state_n == IO_RD ? {2'b11, bank, cfg} : 8'h00;
        end
    end
`else
    assign doe = 1'b0;
    assign dout = 8'h00;
`endif
endmodule

// File: tb/tb_cpc_ram_ctrl.sv
// tb_cpc_ram_ctrl: directed self-checking bench for cpc_ram_ctrl
module tb_cpc_ram_ctrl;
    logic clk = 1'b0;
    logic reset_b, a15, a14, mreq_b, ioreq_b, rd_b, wr_b, m1_b, rfsh_b, ramrd_b;
    logic [7:0] d, dout;
    logic [4:0] hiadr;
    logic ramcs_b, ramoe_b, ramwe_b, ramdis, doe;
    int n_cmp = 0;
    int n_bad = 0;

    cpc_ram_ctrl dut (
        .clk(clk), .reset_b(reset_b), .a15(a15), .a14(a14), .d(d),
        .mreq_b(mreq_b), .ioreq_b(ioreq_b), .rd_b(rd_b), .wr_b(wr_b),
        .m1_b(m1_b), .rfsh_b(rfsh_b), .ramrd_b(ramrd_b),
        .hiadr(hiadr), .ramcs_b(ramcs_b), .ramoe_b(ramoe_b), .ramwe_b(ramwe_b),
        .ramdis(ramdis), .dout(dout), .doe(doe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        mreq_b = 1'b1; ioreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
        m1_b = 1'b1; rfsh_b = 1'b1; ramrd_b = 1'b1;
    endtask

    task automatic io_wr(input logic [7:0] v);
        a15 = 1'b0; a14 = 1'b1; d = v; ioreq_b = 1'b0; wr_b = 1'b0;
        tick();
        idle_bus();
        tick();
    endtask

    task automatic mem_rd(input logic h, input logic l);
        a15 = h; a14 = l; mreq_b = 1'b0; rd_b = 1'b0; ramrd_b = 1'b0;
        tick();
    endtask

    initial begin
        idle_bus();
        a15 = 1'b0; a14 = 1'b0; d = 8'h00; reset_b = 1'b0;
        tick();
        tick();
        chk("rst_cs", {7'd0, ramcs_b}, 8'd1);
        chk("rst_oe", {7'd0, ramoe_b}, 8'd1);
        chk("rst_we", {7'd0, ramwe_b}, 8'd1);
        chk("rst_dis", {7'd0, ramdis}, 8'd0);
        chk("rst_hiadr", {3'd0, hiadr}, 8'd0);
        chk("rst_doe", {7'd0, doe}, 8'd0);
        reset_b = 1'b1;
        mem_rd(1'b1, 1'b1);
        chk("cfg0_cs", {7'd0, ramcs_b}, 8'd1);
        chk("cfg0_dis", {7'd0, ramdis}, 8'd0);
        idle_bus(); tick();
        io_wr(8'hC1);
        mem_rd(1'b1, 1'b1);
        chk("cfg1_hiadr", {3'd0, hiadr}, 8'h03);
        chk("cfg1_cs", {7'd0, ramcs_b}, 8'd0);
        chk("cfg1_oe", {7'd0, ramoe_b}, 8'd0);
        chk("cfg1_we", {7'd0, ramwe_b}, 8'd1);
        chk("cfg1_dis", {7'd0, ramdis}, 8'd1);
        idle_bus(); tick();
        chk("end_cs", {7'd0, ramcs_b}, 8'd1);
        chk("end_oe", {7'd0, ramoe_b}, 8'd1);
        chk("end_dis", {7'd0, ramdis}, 8'd0);
        mem_rd(1'b0, 1'b1);
        chk("cfg1_4000_cs", {7'd0, ramcs_b}, 8'd1);
        idle_bus(); tick();
        io_wr(8'hFE);
        a15 = 1'b0; a14 = 1'b1; mreq_b = 1'b0;
        tick();
        chk("wr_hiadr", {3'd0, hiadr}, 8'h1E);
        chk("wr_cs", {7'd0, ramcs_b}, 8'd0);
        chk("wr_we_pre", {7'd0, ramwe_b}, 8'd1);
        wr_b = 1'b0;
        tick();
        chk("wr_we_low", {7'd0, ramwe_b}, 8'd0);
        chk("wr_oe_high", {7'd0, ramoe_b}, 8'd1);
        tick();
        chk("wr_we_hold", {7'd0, ramwe_b}, 8'd0);
        wr_b = 1'b1;
        tick();
        chk("wr_we_rise", {7'd0, ramwe_b}, 8'd1);
        chk("wr_cs_hold", {7'd0, ramcs_b}, 8'd0);
        chk("wr_hiadr_hold", {3'd0, hiadr}, 8'h1E);
        idle_bus(); tick();
        chk("wr_end_cs", {7'd0, ramcs_b}, 8'd1);
        io_wr(8'hC2);
        a15 = 1'b1; a14 = 1'b1; mreq_b = 1'b0; rfsh_b = 1'b0;
        tick();
        chk("rfsh_cs", {7'd0, ramcs_b}, 8'd1);
        chk("rfsh_dis", {7'd0, ramdis}, 8'd0);
        idle_bus(); tick();
        a15 = 1'b0; a14 = 1'b1; d = 8'hC1; ioreq_b = 1'b0; m1_b = 1'b0; wr_b = 1'b0;
        tick();
        idle_bus(); tick();
        mem_rd(1'b0, 1'b1);
        chk("inta_cs", {7'd0, ramcs_b}, 8'd0);
        chk("inta_hiadr", {3'd0, hiadr}, 8'h01);
        idle_bus(); tick();
        io_wr(8'hF9);
        mem_rd(1'b1, 1'b1);
        chk("pre_rst_hiadr", {3'd0, hiadr}, 8'h1F);
        reset_b = 1'b0;
        tick();
        chk("mid_rst_cs", {7'd0, ramcs_b}, 8'd1);
        chk("mid_rst_oe", {7'd0, ramoe_b}, 8'd1);
        chk("mid_rst_dis", {7'd0, ramdis}, 8'd0);
        chk("mid_rst_hiadr", {3'd0, hiadr}, 8'h00);
        reset_b = 1'b1;
        idle_bus(); tick();
        mem_rd(1'b1, 1'b1);
        chk("post_rst_cs", {7'd0, ramcs_b}, 8'd1);
        idle_bus(); tick();
        io_wr(8'hD5);
        a15 = 1'b0; a14 = 1'b1; ioreq_b = 1'b0; rd_b = 1'b0;
        tick();
`ifdef CONFIG_READBACK_EN
        chk("rb_doe", {7'd0, doe}, 8'd1);
        chk("rb_dout", dout, 8'hD5);
`else
        chk("rb_doe", {7'd0, doe}, 8'd0);
        chk("rb_dout", dout, 8'h00);
`endif
        chk("rb_cs", {7'd0, ramcs_b}, 8'd1);
        idle_bus(); tick();
        chk("rb_doe_end", {7'd0, doe}, 8'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
